// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM port arbiter.
// Holds the controller state enum, the requester-id type and the
// statistics-counter width/saturation constants used when SRAM_ARB_STATS_EN
// is defined.
package sram_arb_pkg;

  // Controller states: normal arbitration or the full-memory clear sweep.
  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

  // Identifies one of the two requesters.
  typedef logic req_id_t;

  localparam req_id_t REQ_M0 = 1'b0;
  localparam req_id_t REQ_M1 = 1'b1;

  // Statistics counters are 32 bits wide and stick at all-ones.
  localparam int unsigned STAT_W = 32;
  localparam logic [STAT_W-1:0] STAT_SAT = {STAT_W{1'b1}};

  // Saturating increment used by every statistics counter.
  function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] value,
                                               input logic en);
    logic [STAT_W-1:0] result;
    result = value;
    if (en && (value != STAT_SAT)) begin
      result = value + STAT_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin grant generator.
// A lone requester is granted directly; when both request, the one that did
// not win last time is granted. The last winner only moves when a grant is
// actually issued, and no grant is issued while 'advance' is low.
module sram_rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  req_id_t lastGrant_q;
  req_id_t lastGrant_d;

  // Combinational one-hot grant and the next value of the last-winner record.
  always_comb begin
    grant       = 2'b00;
    lastGrant_d = lastGrant_q;
    if (advance) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (lastGrant_q == REQ_M1) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    if (grant[0]) begin
      lastGrant_d = REQ_M0;
    end else if (grant[1]) begin
      lastGrant_d = REQ_M1;
    end
  end

  // Last-winner register; resetting it to m1 lets m0 win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant_q <= REQ_M1;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM (1-cycle read latency) between two Avalon-MM
// requesters with round-robin arbitration at one access per cycle, and
// provides a clear sequencer that fills the whole SRAM with CLEAR_VALUE.
// Optional feature macro: SRAM_ARB_STATS_EN adds saturating grant and
// conflict counters as extra outputs.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int                ADDR_W      = 10,
  parameter int                DATA_W      = 32,
  parameter int                BE_W        = DATA_W / 8,
  parameter int                DEPTH       = 1024,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] sram_address,
  output logic [BE_W-1:0]   sram_byteenable,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [DATA_W-1:0] sram_writedata,
  output logic              sram_clken,
  input  logic [DATA_W-1:0] sram_readdata,

  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] m0_grant_count,
  output logic [STAT_W-1:0] m1_grant_count,
  output logic [STAT_W-1:0] conflict_count
`endif
);

  // One extra counter bit lets DEPTH == 2**ADDR_W finish without wrapping.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic [CNT_W-1:0] clearCnt_q;
  logic [CNT_W-1:0] clearCnt_d;
  logic             clearDone_q;
  logic             clearDone_d;
  logic             rdValid_q;
  logic             rdValid_d;
  req_id_t          rdOwner_q;
  req_id_t          rdOwner_d;

  logic [1:0] req;
  logic [1:0] grant;
  logic       advance;
  logic       anyGrant;
  req_id_t    gntId;
  logic       selWrite;
  logic       selRead;

  // A write strobe wins over a simultaneous read strobe on the same requester.
  assign req[0]   = m0_read | m0_write;
  assign req[1]   = m1_read | m1_write;
  assign advance  = (state_q == ARB) & ~clear_start & ~reset;
  assign anyGrant = |grant;
  assign gntId    = grant[1] ? REQ_M1 : REQ_M0;
  assign selWrite = (gntId == REQ_M1) ? m1_write : m0_write;
  assign selRead  = anyGrant & ~selWrite;

  sram_rr_arb2 u_rr_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  // Next-state logic for the arbitrate/clear controller and the clear counter.
  always_comb begin
    state_d     = state_q;
    clearCnt_d  = clearCnt_q;
    clearDone_d = 1'b0;
    unique case (state_q)
      ARB: begin
        if (clear_start) begin
          state_d    = CLEAR;
          clearCnt_d = '0;
        end
      end
      CLEAR: begin
        if (clearCnt_q == LAST_CNT) begin
          state_d     = ARB;
          clearCnt_d  = '0;
          clearDone_d = 1'b1;
        end else begin
          clearCnt_d = clearCnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  // SRAM port drive: the granted requester in ARB, the fill word in CLEAR,
  // and nothing at all while reset is held so an aborted clear stops at once.
  always_comb begin
    sram_address    = '0;
    sram_byteenable = '0;
    sram_chipselect = 1'b0;
    sram_write      = 1'b0;
    sram_writedata  = '0;
    if (!reset) begin
      unique case (state_q)
        ARB: begin
          if (anyGrant) begin
            sram_chipselect = 1'b1;
            sram_write      = selWrite;
            if (gntId == REQ_M1) begin
              sram_address    = m1_address;
              sram_byteenable = m1_byteenable;
              sram_writedata  = m1_writedata;
            end else begin
              sram_address    = m0_address;
              sram_byteenable = m0_byteenable;
              sram_writedata  = m0_writedata;
            end
          end
        end
        CLEAR: begin
          sram_chipselect = 1'b1;
          sram_write      = 1'b1;
          sram_address    = clearCnt_q[ADDR_W-1:0];
          sram_byteenable = '1;
          sram_writedata  = CLEAR_VALUE;
        end
        default: begin
          sram_chipselect = 1'b0;
        end
      endcase
    end
  end

  // Read-return tracking: a granted read produces valid data next cycle,
  // tagged with the requester that issued it.
  always_comb begin
    rdValid_d = selRead;
    rdOwner_d = rdOwner_q;
    if (selRead) begin
      rdOwner_d = gntId;
    end
  end

  // Controller, clear counter and read-return registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      clearCnt_q  <= '0;
      clearDone_q <= 1'b0;
      rdValid_q   <= 1'b0;
      rdOwner_q   <= REQ_M0;
    end else begin
      state_q     <= state_d;
      clearCnt_q  <= clearCnt_d;
      clearDone_q <= clearDone_d;
      rdValid_q   <= rdValid_d;
      rdOwner_q   <= rdOwner_d;
    end
  end

  assign sram_clken       = 1'b1;
  assign m0_waitrequest   = req[0] & ~grant[0];
  assign m1_waitrequest   = req[1] & ~grant[1];
  assign m0_readdata      = sram_readdata;
  assign m1_readdata      = sram_readdata;
  assign m0_readdatavalid = rdValid_q & (rdOwner_q == REQ_M0);
  assign m1_readdatavalid = rdValid_q & (rdOwner_q == REQ_M1);
  assign clear_busy       = (state_q == CLEAR);
  assign clear_done       = clearDone_q;

`ifdef SRAM_ARB_STATS_EN
  logic [STAT_W-1:0] m0Count_q;
  logic [STAT_W-1:0] m1Count_q;
  logic [STAT_W-1:0] conflictCount_q;
  logic              conflict;

  // A conflict is any arbitration-state cycle in which both requesters ask.
  assign conflict = (state_q == ARB) & req[0] & req[1] & ~reset;

  // Saturating statistics; grants and conflicts never occur in CLEAR, so
  // the counters hold still for the whole sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      m0Count_q       <= '0;
      m1Count_q       <= '0;
      conflictCount_q <= '0;
    end else begin
      m0Count_q       <= satInc(m0Count_q, grant[0]);
      m1Count_q       <= satInc(m1Count_q, grant[1]);
      conflictCount_q <= satInc(conflictCount_q, conflict);
    end
  end

  assign m0_grant_count = m0Count_q;
  assign m1_grant_count = m1Count_q;
  assign conflict_count = conflictCount_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural SRAM and a
// reference model built from the arbitration rules (round-robin winner,
// byte-merged memory image, one-cycle read return).
// Optional feature macro: SRAM_ARB_STATS_EN enables the counter checks.
module tb_sram_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int DEPTH  = 1024;
  localparam logic [31:0] CLEAR_VALUE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [9:0]  sram_address;
  logic [3:0]  sram_byteenable;
  logic        sram_chipselect, sram_write, sram_clken;
  logic [31:0] sram_writedata, sram_readdata;
  logic        clear_start, clear_busy, clear_done;
`ifdef SRAM_ARB_STATS_EN
  logic [31:0] m0_grant_count, m1_grant_count, conflict_count;
`endif

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .DEPTH(DEPTH),
    .CLEAR_VALUE(CLEAR_VALUE)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .sram_address(sram_address), .sram_byteenable(sram_byteenable),
    .sram_chipselect(sram_chipselect), .sram_write(sram_write),
    .sram_writedata(sram_writedata), .sram_clken(sram_clken),
    .sram_readdata(sram_readdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
`ifdef SRAM_ARB_STATS_EN
    , .m0_grant_count(m0_grant_count), .m1_grant_count(m1_grant_count),
    .conflict_count(conflict_count)
`endif
  );

  // Initial memory image shared by the SRAM model and the reference model.
  function automatic logic [31:0] initWord(input int idx);
    if (idx == 5)    return 32'h1234_5678;
    if (idx == 1023) return 32'hFFFF_FFFF;
    return (32'(idx) * 32'h0001_0003) ^ 32'h5A5A_0001;
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW,
                                             input logic [31:0] newW,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = oldW;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = newW[8*b +: 8];
    return r;
  endfunction

  // Behavioural SRAM: byte-enabled write, read data on q the next cycle.
  logic [31:0] sramMem [DEPTH];
  logic [31:0] sramQ = 32'h0;
  logic        loadEn;
  always @(posedge clk) begin
    if (loadEn) begin
      for (int i = 0; i < DEPTH; i++) sramMem[i] <= initWord(i);
    end else if (sram_chipselect && sram_clken) begin
      if (sram_write) begin
        for (int b = 0; b < 4; b++)
          if (sram_byteenable[b]) sramMem[sram_address][8*b +: 8] <= sram_writedata[8*b +: 8];
      end else begin
        sramQ <= sramMem[sram_address];
      end
    end
  end
  assign sram_readdata = sramQ;

  // Reference model state.
  logic [31:0] refMem [DEPTH];
  int          lastWinner;
  logic        expValid;
  int          expOwner;
  logic [31:0] expData;
  int          lastG;
  int          testsRun = 0;
  int          failCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checkOutput(tag, {31'b0, observed}, {31'b0, expected});
  endtask

  task automatic driveIdle();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    clear_start = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    driveIdle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lastWinner = 1;
    expValid = 1'b0;
  endtask

  // One arbitration cycle: drive, check against the model, advance the model.
  task automatic applyStimulus(input logic r0, input logic w0, input logic [9:0] a0,
                               input logic [3:0] be0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [9:0] a1,
                               input logic [3:0] be1, input logic [31:0] d1,
                               input logic cs);
    logic q0, q1, gw;
    logic [9:0] ga;
    int g;
    @(negedge clk);
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    clear_start = cs;
    #1;
    q0 = r0 | w0;
    q1 = r1 | w1;
    g = -1;
    if (!cs) begin
      if (q0 && q1) g = (lastWinner == 1) ? 0 : 1;
      else if (q0)  g = 0;
      else if (q1)  g = 1;
    end
    lastG = g;
    checkBit("wait0", m0_waitrequest, q0 && (g != 0));
    checkBit("wait1", m1_waitrequest, q1 && (g != 1));
    checkBit("rdv0", m0_readdatavalid, expValid && (expOwner == 0));
    checkBit("rdv1", m1_readdatavalid, expValid && (expOwner == 1));
    if (expValid) checkOutput("rdata", (expOwner == 0) ? m0_readdata : m1_readdata, expData);
    checkBit("chipselect", sram_chipselect, g >= 0);
    expValid = 1'b0;
    if (g >= 0) begin
      gw = (g == 1) ? w1 : w0;
      ga = (g == 1) ? a1 : a0;
      checkOutput("sram_addr", 32'(sram_address), 32'(ga));
      checkBit("sram_write", sram_write, gw);
      if (gw) begin
        checkOutput("sram_be", 32'(sram_byteenable), 32'((g == 1) ? be1 : be0));
        checkOutput("sram_wdata", sram_writedata, (g == 1) ? d1 : d0);
        refMem[ga] = mergeBytes(refMem[ga], (g == 1) ? d1 : d0, (g == 1) ? be1 : be0);
      end else begin
        expValid = 1'b1;
        expOwner = g;
        expData  = refMem[ga];
      end
      lastWinner = g;
    end
  endtask

  task automatic idleStep();
    applyStimulus(0, 0, 10'h0, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0, 0);
  endtask

  task automatic bothRead(input logic [9:0] a0, input logic [9:0] a1);
    applyStimulus(1, 0, a0, 4'h0, 32'h0, 1, 0, a1, 4'h0, 32'h0, 0);
  endtask

  task automatic randomStep();
    int m0m, m1m;
    m0m = $urandom_range(0, 3);
    m1m = $urandom_range(0, 3);
    applyStimulus(m0m[0], m0m[1], 10'($urandom), 4'($urandom), $urandom,
                  m1m[0], m1m[1], 10'($urandom), 4'($urandom), $urandom, 0);
  endtask

  // Starts a clear (after one m0 read), sweeps it, optionally aborting with
  // reset when the counter reaches abortAt.
  task automatic runClear(input int abortAt);
    applyStimulus(1, 0, 10'($urandom), 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0, 0);
    applyStimulus(1, 0, 10'h011, 4'h0, 32'h0, 1, 0, 10'h022, 4'h0, 32'h0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      clear_start = (i == 5);
      if (i == abortAt) reset = 1'b1;
      #1;
      checkBit("clear_busy", clear_busy, 1'b1);
      checkBit("clear_wait0", m0_waitrequest, 1'b1);
      checkBit("clear_wait1", m1_waitrequest, 1'b1);
      checkBit("clear_done_low", clear_done, 1'b0);
      if (i == abortAt) break;
      checkBit("clear_write", sram_write, 1'b1);
      checkOutput("clear_addr", 32'(sram_address), 32'(i));
      checkOutput("clear_data", sram_writedata, CLEAR_VALUE);
      checkOutput("clear_be", 32'(sram_byteenable), 32'hF);
      refMem[i] = CLEAR_VALUE;
    end
  endtask

  initial begin
    reset = 1'b1;
    loadEn = 1'b1;
    driveIdle();
    lastWinner = 1;
    expValid = 1'b0;
    expOwner = 0;
    expData = '0;
    lastG = -1;
    for (int i = 0; i < DEPTH; i++) refMem[i] = initWord(i);
    repeat (2) @(negedge clk);
    loadEn = 1'b0;
    m0_read = 1'b1;
    m1_read = 1'b1;
    #1;
    checkBit("rst_chipselect", sram_chipselect, 1'b0);
    checkBit("rst_write", sram_write, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    driveIdle();
    #1;
    checkBit("rst_busy", clear_busy, 1'b0);
    checkBit("rst_done", clear_done, 1'b0);
    checkBit("rst_rdv0", m0_readdatavalid, 1'b0);
    checkBit("rst_rdv1", m1_readdatavalid, 1'b0);
    checkBit("rst_idle_cs", sram_chipselect, 1'b0);
    checkBit("rst_idle_wait0", m0_waitrequest, 1'b0);

    // Single m0 read of a preloaded word.
    applyStimulus(1, 0, 10'h005, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0, 0);
    idleStep();
    checkOutput("read_005", m0_readdata, 32'h1234_5678);

    // Both requesting after reset: strict alternation starting with m0.
    doReset();
    for (int i = 0; i < 6; i++) begin
      bothRead(10'($urandom), 10'($urandom));
      checkOutput("rr_seq", 32'(lastG), 32'(i % 2));
    end
    idleStep();

    // Partial-byte write then readback.
    applyStimulus(0, 0, 10'h0, 4'h0, 32'h0, 0, 1, 10'h3FF, 4'b0011, 32'hDEAD_BEEF, 0);
    applyStimulus(1, 0, 10'h3FF, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0, 0);
    idleStep();
    checkOutput("be_merge", m0_readdata, 32'hFFFF_BEEF);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) randomStep();
    idleStep();

`ifdef SRAM_ARB_STATS_EN
    doReset();
    for (int i = 0; i < 10; i++) bothRead(10'($urandom), 10'($urandom));
    idleStep();
    checkOutput("stat_m0", m0_grant_count, 32'd5);
    checkOutput("stat_m1", m1_grant_count, 32'd5);
    checkOutput("stat_conflict", conflict_count, 32'd10);
`endif

    // Clear aborted by reset at word 100.
    runClear(100);
    @(negedge clk);
    #1;
    checkBit("abort_busy", clear_busy, 1'b0);
    reset = 1'b0;
    driveIdle();
    lastWinner = 1;
    expValid = 1'b0;
    bothRead(10'd50, 10'd100);
    checkOutput("abort_tie", 32'(lastG), 32'd0);
    bothRead(10'd99, 10'd101);
    idleStep();

    // Full clear, with a second clear_start ignored mid-sweep.
    runClear(-1);
    idleStep();
    checkBit("done_pulse", clear_done, 1'b1);
    checkBit("busy_after", clear_busy, 1'b0);
    idleStep();
    checkBit("done_single", clear_done, 1'b0);
    bothRead(10'h000, 10'h200);
    applyStimulus(1, 0, 10'h3FF, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0, 0);
    idleStep();
    checkOutput("clear_3ff", m0_readdata, CLEAR_VALUE);
    idleStep();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
